// File: rtl/audio_pkg.sv
// Shared audio-chain constants: I2S frame geometry, legal sample widths
// and the one-bit I2S data delay.
package audio_pkg;

  localparam int FRAME_BCLKS    = 64;
  localparam int SLOT_BCLKS     = 32;
  localparam int CNT_W          = $clog2(FRAME_BCLKS);
  localparam int BITSIZE_16     = 16;
  localparam int BITSIZE_24     = 24;
  localparam int I2S_DELAY_BITS = 1;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } i2s_chan_e;

  function automatic bit is_legal_bitsize(input int bs);
    return (bs == BITSIZE_16) || (bs == BITSIZE_24);
  endfunction

endpackage

// File: rtl/i2s_slot_shifter.sv
// One channel's parallel-load, MSB-first shift register for the I2S transmitter.
module i2s_slot_shifter #(
  parameter int BITSIZE = 16
) (
  input  logic                      bclk,
  input  logic                      reset,
  input  logic                      load,
  input  logic                      shift,
  input  logic signed [BITSIZE-1:0] din,
  output logic                      msb
);

  logic signed [BITSIZE-1:0] word_q, word_d;

  always_comb begin
    word_d = word_q;
    if (load) begin
      word_d = din;
    end else if (shift) begin
      word_d = {word_q[BITSIZE-2:0], 1'b0};
    end
  end

  always_ff @(posedge bclk or posedge reset) begin
    if (reset) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign msb = word_q[BITSIZE-1];

endmodule

// File: rtl/i2s_transmitter.sv
// I2S transmitter: one-deep stereo holding buffer, 64-bclk frame, registered outputs.
// Optional I2S_TX_HOLD_LAST_EN: underrun frames repeat the last transmitted pair.
module i2s_transmitter
  import audio_pkg::*;
#(
  parameter int BITSIZE = 16
) (
  input  logic                      bclk,
  input  logic                      reset,
  input  logic signed [BITSIZE-1:0] left,
  input  logic signed [BITSIZE-1:0] right,
  input  logic                      valid,
  output logic                      ready,
  output logic                      lrclk,
  output logic                      sdata,
  output logic                      underrun
);

  localparam int                SLOT_W     = $clog2(SLOT_BCLKS);
  localparam logic [SLOT_W-1:0] DATA_FIRST = SLOT_W'(I2S_DELAY_BITS);
  localparam logic [SLOT_W-1:0] DATA_LAST  = SLOT_W'(I2S_DELAY_BITS + BITSIZE - 1);
  localparam logic [CNT_W-1:0]  LAST_BCLK  = CNT_W'(FRAME_BCLKS - 1);

  generate
    if (!is_legal_bitsize(BITSIZE)) begin : g_bitsize_check
      $error("i2s_transmitter: BITSIZE must be 16 or 24, got %0d", BITSIZE);
    end
  endgenerate

  logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
  logic                      lrclk_q, lrclk_d;
  logic                      sdata_q, sdata_d;
  logic                      ready_q, ready_d;
  logic                      underrun_q, underrun_d;
  logic                      full_q, full_d;
  logic signed [BITSIZE-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
  logic signed [BITSIZE-1:0] load_l, load_r;
  logic [SLOT_W-1:0]         slot_d;
  i2s_chan_e                 chan_d;
  logic                      frame_end, handshake, in_data;
  logic                      shift_l, shift_r, msb_l, msb_r;

  // Outputs are computed from the count being entered so they line up with bit_cnt.
  always_comb begin
    bit_cnt_d  = bit_cnt_q + CNT_W'(1);
    frame_end  = (bit_cnt_q == LAST_BCLK);
    handshake  = valid && ready_q;
    chan_d     = i2s_chan_e'(bit_cnt_d[CNT_W-1]);
    slot_d     = bit_cnt_d[SLOT_W-1:0];
    in_data    = (slot_d >= DATA_FIRST) && (slot_d <= DATA_LAST);
    shift_l    = in_data && (chan_d == CH_LEFT);
    shift_r    = in_data && (chan_d == CH_RIGHT);
    lrclk_d    = (chan_d == CH_RIGHT);
    sdata_d    = in_data && ((chan_d == CH_RIGHT) ? msb_r : msb_l);
    underrun_d = frame_end && !full_q;

    // A handshake on the load edge refills the buffer the load just found empty.
    full_d = full_q;
    if (frame_end) full_d = 1'b0;
    if (handshake) full_d = 1'b1;
    ready_d = !full_d;

    buf_l_d = handshake ? left  : buf_l_q;
    buf_r_d = handshake ? right : buf_r_q;
  end

`ifdef I2S_TX_HOLD_LAST_EN
  logic signed [BITSIZE-1:0] last_l_q, last_l_d, last_r_q, last_r_d;

  always_comb begin
    load_l   = full_q ? buf_l_q : last_l_q;
    load_r   = full_q ? buf_r_q : last_r_q;
    last_l_d = frame_end ? load_l : last_l_q;
    last_r_d = frame_end ? load_r : last_r_q;
  end

  always_ff @(posedge bclk or posedge reset) begin
    if (reset) begin
      last_l_q <= '0;
      last_r_q <= '0;
    end else begin
      last_l_q <= last_l_d;
      last_r_q <= last_r_d;
    end
  end
`else
  always_comb begin
    load_l = full_q ? buf_l_q : '0;
    load_r = full_q ? buf_r_q : '0;
  end
`endif

  always_ff @(posedge bclk or posedge reset) begin
    if (reset) begin
      bit_cnt_q  <= '0;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
      ready_q    <= 1'b1;
      underrun_q <= 1'b0;
      full_q     <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      ready_q    <= ready_d;
      underrun_q <= underrun_d;
      full_q     <= full_d;
    end
  end

  // Buffer contents are qualified by full_q and need no reset.
  always_ff @(posedge bclk) begin
    buf_l_q <= buf_l_d;
    buf_r_q <= buf_r_d;
  end

  i2s_slot_shifter #(.BITSIZE(BITSIZE)) u_shift_left (
    .bclk  (bclk),
    .reset (reset),
    .load  (frame_end),
    .shift (shift_l),
    .din   (load_l),
    .msb   (msb_l)
  );

  i2s_slot_shifter #(.BITSIZE(BITSIZE)) u_shift_right (
    .bclk  (bclk),
    .reset (reset),
    .load  (frame_end),
    .shift (shift_r),
    .din   (load_r),
    .msb   (msb_r)
  );

  assign ready    = ready_q;
  assign lrclk    = lrclk_q;
  assign sdata    = sdata_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Self-checking bench for i2s_transmitter: frame-level reference model plus
// literal frame captures; honours I2S_TX_HOLD_LAST_EN when defined.
module tb_i2s_transmitter;

  localparam int BS = 16;
`ifdef I2S_TX_HOLD_LAST_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic                 bclk = 1'b0;
  logic                 reset = 1'b0;
  logic signed [BS-1:0] left_in = '0;
  logic signed [BS-1:0] right_in = '0;
  logic                 valid = 1'b0;
  logic                 ready, lrclk, sdata, underrun;

  int vectors = 0;
  int miscompares = 0;

  always #5 bclk = ~bclk;

  i2s_transmitter #(.BITSIZE(BS)) dut (
    .bclk     (bclk),
    .reset    (reset),
    .left     (left_in),
    .right    (right_in),
    .valid    (valid),
    .ready    (ready),
    .lrclk    (lrclk),
    .sdata    (sdata),
    .underrun (underrun)
  );

  // Reference model: frame position, one-deep buffer, pair on air, last pair.
  int          m_c;
  logic        m_full, m_ur;
  logic [BS-1:0] m_buf_l, m_buf_r, m_cur_l, m_cur_r, m_last_l, m_last_r;

  always @(posedge bclk or posedge reset) begin
    if (reset) begin
      m_c      <= 0;
      m_full   <= 1'b0;
      m_ur     <= 1'b0;
      m_cur_l  <= '0;
      m_cur_r  <= '0;
      m_last_l <= '0;
      m_last_r <= '0;
    end else begin
      m_c  <= (m_c + 1) % 64;
      m_ur <= (m_c == 63) && !m_full;
      if (m_c == 63) begin
        if (m_full) begin
          m_cur_l  <= m_buf_l;
          m_cur_r  <= m_buf_r;
          m_last_l <= m_buf_l;
          m_last_r <= m_buf_r;
        end else begin
          m_cur_l <= HOLD ? m_last_l : '0;
          m_cur_r <= HOLD ? m_last_r : '0;
        end
      end
      if (valid && !m_full) begin
        m_buf_l <= left_in;
        m_buf_r <= right_in;
        m_full  <= 1'b1;
      end else if (m_c == 63) begin
        m_full <= 1'b0;
      end
    end
  end

  function automatic logic exp_sdata(input int c, input logic [BS-1:0] l, input logic [BS-1:0] r);
    logic [BS-1:0] w;
    int s;
    s = c % 32;
    w = (c < 32) ? l : r;
    if (s >= 1 && s <= BS) return w[BS - s];
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge bclk) begin
    if (!reset) begin
      chk("lrclk", 32'(lrclk), 32'(m_c >= 32));
      chk("sdata", 32'(sdata), 32'(exp_sdata(m_c, m_cur_l, m_cur_r)));
      chk("ready", 32'(ready), 32'(!m_full));
      chk("underrun", 32'(underrun), 32'(m_ur));
    end
  end

  task automatic wait_c(input int target);
    int n;
    n = 0;
    while (m_c != target && n < 200) begin
      @(negedge bclk);
      n++;
    end
    chk("wait_c", 32'(m_c), 32'(target));
  endtask

  // lb[31-k] holds sdata at c=k, rb[63-k] at c=k; ur0/rdy0 are sampled at c=0.
  task automatic grab(output logic [31:0] lb, output logic [31:0] rb,
                      output logic ur0, output logic rdy0);
    wait_c(0);
    ur0  = underrun;
    rdy0 = ready;
    lb   = '0;
    rb   = '0;
    for (int k = 0; k < 64; k++) begin
      if (k > 0) @(negedge bclk);
      if (k < 32) lb[31-k] = sdata;
      else        rb[63-k] = sdata;
    end
  endtask

  task automatic offer(input logic [BS-1:0] l, input logic [BS-1:0] r);
    left_in  = l;
    right_in = r;
    valid    = 1'b1;
    @(negedge bclk);
    valid    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0]   lb, rb;
    logic          ur0, rdy0;
    logic [BS-1:0] pl, pr, ql, qr;
    int            ur_seen;

    #1 reset = 1'b1;
    #2;
    chk("rst_lrclk", 32'(lrclk), 32'd0);
    chk("rst_sdata", 32'(sdata), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_underrun", 32'(underrun), 32'd0);
    repeat (3) @(negedge bclk);
    reset = 1'b0;

    // Idle frames after reset: silent, first frame without underrun.
    grab(lb, rb, ur0, rdy0);
    chk("f1_underrun", 32'(ur0), 32'd0);
    chk("f1_left", lb, 32'h0);
    chk("f1_right", rb, 32'h0);
    grab(lb, rb, ur0, rdy0);
    chk("f2_underrun", 32'(ur0), 32'd1);
    chk("f2_left", lb, 32'h0);
    grab(lb, rb, ur0, rdy0);
    chk("f3_underrun", 32'(ur0), 32'd1);

    // Known pair accepted mid-frame.
    wait_c(10);
    left_in  = 16'hA5C3;
    right_in = 16'h8001;
    valid    = 1'b1;
    @(negedge bclk);
    valid = 1'b0;
    chk("a5_ready_low", 32'(ready), 32'd0);
    grab(lb, rb, ur0, rdy0);
    chk("a5_underrun", 32'(ur0), 32'd0);
    chk("a5_ready_c0", 32'(rdy0), 32'd1);
    chk("a5_left", lb, 32'h52E18000);
    chk("a5_right", rb, 32'h40008000);

    // Pair offered at c=63 with the buffer empty.
    pl = BS'($urandom);
    pr = BS'($urandom);
    offer(pl, pr);
    chk("c63_underrun", 32'(underrun), 32'd1);
    grab(lb, rb, ur0, rdy0);
    chk("c63_zero_ur", 32'(ur0), 32'd1);
    chk("c63_zero_left", lb, HOLD ? 32'h52E18000 : 32'h0);
    grab(lb, rb, ur0, rdy0);
    chk("c63_pair_ur", 32'(ur0), 32'd0);
    chk("c63_pair_left", lb, {1'b0, pl, 15'b0});
    chk("c63_pair_right", rb, {1'b0, pr, 15'b0});

    // Continuous streaming with random pairs.
    wait_c(5);
    ur_seen = 0;
    for (int i = 0; i < 8 * 64; i++) begin
      if (!m_full) begin
        left_in  = BS'($urandom);
        right_in = BS'($urandom);
      end
      valid = 1'b1;
      @(negedge bclk);
      ur_seen += int'(underrun);
    end
    valid = 1'b0;
    chk("stream_underruns", 32'(ur_seen), 32'd0);

    // Reset in the middle of an all-ones right slot.
    wait_c(0);
    wait_c(40);
    offer(16'hFFFF, 16'hFFFF);
    wait_c(40);
    chk("pre_rst_sdata", 32'(sdata), 32'd1);
    chk("pre_rst_lrclk", 32'(lrclk), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_sdata", 32'(sdata), 32'd0);
    chk("mid_rst_lrclk", 32'(lrclk), 32'd0);
    chk("mid_rst_underrun", 32'(underrun), 32'd0);
    chk("mid_rst_ready", 32'(ready), 32'd1);
    repeat (3) @(negedge bclk);
    reset = 1'b0;
    grab(lb, rb, ur0, rdy0);
    chk("post_rst_left", lb, 32'h0);
    chk("post_rst_right", rb, 32'h0);
    chk("post_rst_ur", 32'(ur0), 32'd0);
    chk("post_rst_ready", 32'(rdy0), 32'd1);

    // Single pair followed by an underrun frame.
    wait_c(5);
    ql = BS'($urandom);
    qr = BS'($urandom);
    offer(ql, qr);
    grab(lb, rb, ur0, rdy0);
    chk("q_left", lb, {1'b0, ql, 15'b0});
    chk("q_right", rb, {1'b0, qr, 15'b0});
    grab(lb, rb, ur0, rdy0);
    chk("q_next_ur", 32'(ur0), 32'd1);
    chk("q_next_left", lb, HOLD ? {1'b0, ql, 15'b0} : 32'h0);
    chk("q_next_right", rb, HOLD ? {1'b0, qr, 15'b0} : 32'h0);

    @(negedge bclk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
